// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory/writeback slice:
// funct3 load/store sizes, writeback source selects, FSM state type.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_PC4 = 2'b10;
    localparam logic [1:0] SRC_IMM = 2'b11;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_wr;
        logic [1:0] src;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
        logic       is_load;
    } pend_t;

    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        if (f3 == F3_H || f3 == F3_HU) return lo[0];
        if (f3 == F3_W) return lo != 2'b00;
        return 1'b0;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational store byte-enable/replication and load extract/extend.
// Ports: funct3, addr_lo in; st_data, ld_raw in; be, st_wdata, ld_data out.
module load_store_align
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] ld_raw,
    output logic [3:0]      be,
    output logic [XLEN-1:0] st_wdata,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = ld_raw[{addr_lo, 3'b000} +: 8];
        lane_h = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    end

    // Byte enables apply to loads too; the memory just ignores them on reads.
    always_comb begin
        be       = 4'b1111;
        st_wdata = st_data;
        case (funct3[1:0])
            2'b00: begin
                be       = 4'b0001 << addr_lo;
                st_wdata = {(XLEN/8){st_data[7:0]}};
            end
            2'b01: begin
                be       = 4'b0011 << {addr_lo[1], 1'b0};
                st_wdata = {(XLEN/16){st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data = ld_raw;
        case (funct3)
            F3_B:    ld_data = {{(XLEN-8){lane_b[7]}}, lane_b};
            F3_H:    ld_data = {{(XLEN-16){lane_h[15]}}, lane_h};
            F3_BU:   ld_data = {{(XLEN-8){1'b0}}, lane_b};
            F3_HU:   ld_data = {{(XLEN-16){1'b0}}, lane_h};
            default: ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: issues data-memory accesses, waits for dmem_rvalid, and
// drives register writeback. Ports: EX bundle + ex_valid/ex_ready in,
// dmem_* request/response, mem_wb_rd/mem_wb_data/reg_mem_wb_wr out.
// Optional MISALIGN_TRAP_EN adds a misalign output and traps misaligned ops.
module mem_wb_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [31:0]     ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [2:0]      ex_funct3,
    input  logic [4:0]      ex_rd,
    input  logic [1:0]      ex_src_to_reg,
    input  logic            ex_reg_wr,
    input  logic            ex_mem_rd,
    input  logic            ex_mem_wr,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
`ifdef MISALIGN_TRAP_EN
    output logic            misalign,
`endif
    output logic [4:0]      mem_wb_rd,
    output logic [XLEN-1:0] mem_wb_data,
    output logic            reg_mem_wb_wr
);

    state_t          state, state_nx;
    pend_t           pend_q;
    logic            we_q;
    logic [XLEN-1:0] alt_q;
    logic [XLEN-1:0] ex_wb;
    logic [2:0]      al_f3;
    logic [1:0]      al_lo;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_ld;
    logic            accept;
    logic            is_mem;
    logic            trap;
    logic            issue;
    logic            done;

    always_comb begin
        accept = ex_valid && ex_ready;
        is_mem = ex_mem_rd || ex_mem_wr;
`ifdef MISALIGN_TRAP_EN
        trap = is_mem && misaligned(ex_funct3, ex_alu_result[1:0]);
`else
        trap = 1'b0;
`endif
        issue  = accept && is_mem && !trap;
        done   = (state == MEM_WAIT) && dmem_rvalid;
    end

    // Aligner sees the incoming op while idle (store setup) and the
    // pending load while waiting (read data extract).
    always_comb begin
        if (state == MEM_WAIT) begin
            al_f3 = pend_q.funct3;
            al_lo = pend_q.addr_lo;
        end else begin
            al_f3 = ex_funct3;
            al_lo = ex_alu_result[1:0];
        end
    end

    load_store_align #(.XLEN(XLEN)) u_align (
        .funct3  (al_f3),
        .addr_lo (al_lo),
        .st_data (ex_rs2),
        .ld_raw  (dmem_rdata),
        .be      (al_be),
        .st_wdata(al_wdata),
        .ld_data (al_ld)
    );

    always_comb begin
        case (ex_src_to_reg)
            SRC_PC4: ex_wb = XLEN'(ex_pc + 32'd4);
            SRC_IMM: ex_wb = ex_imm;
            default: ex_wb = ex_alu_result;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (issue) state_nx = MEM_WAIT;
            MEM_WAIT: if (dmem_rvalid) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        ex_ready = (state == IDLE);
        dmem_req = (state == MEM_WAIT);
        dmem_we  = dmem_req && we_q;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pend_q        <= '0;
            we_q          <= 1'b0;
            alt_q         <= '0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            mem_wb_rd     <= '0;
            mem_wb_data   <= '0;
            reg_mem_wb_wr <= 1'b0;
        end else begin
            reg_mem_wb_wr <= 1'b0;
            if (accept && !is_mem) begin
                mem_wb_rd     <= ex_rd;
                mem_wb_data   <= ex_wb;
                reg_mem_wb_wr <= ex_reg_wr && (ex_rd != 5'd0);
            end else if (issue) begin
                dmem_addr      <= {ex_alu_result[XLEN-1:2], 2'b00};
                dmem_wdata     <= al_wdata;
                dmem_be        <= al_be;
                we_q           <= ex_mem_wr;
                alt_q          <= ex_wb;
                pend_q.rd      <= ex_rd;
                pend_q.reg_wr  <= ex_reg_wr;
                pend_q.src     <= ex_src_to_reg;
                pend_q.funct3  <= ex_funct3;
                pend_q.addr_lo <= ex_alu_result[1:0];
                pend_q.is_load <= ex_mem_rd && !ex_mem_wr;
            end else if (done && pend_q.is_load) begin
                mem_wb_rd     <= pend_q.rd;
                mem_wb_data   <= (pend_q.src == SRC_MEM) ? al_ld : alt_q;
                reg_mem_wb_wr <= pend_q.reg_wr && (pend_q.rd != 5'd0);
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) misalign <= 1'b0;
        else        misalign <= accept && trap;
    end
`endif

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width.
REQ-002 CLK  in  1  clock, rising-edge active.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 ex_valid  in  1  EX stage presents an instruction.
REQ-005 ex_ready  out  1  stage accepts the instruction this cycle.
REQ-006 ex_alu_result  in  XLEN  ALU result / memory address.
REQ-007 ex_rs2  in  XLEN  store data.
REQ-008 ex_pc  in  32  instruction PC.
REQ-009 ex_imm  in  XLEN  immediate (LUI path).
REQ-010 ex_funct3  in  3  load/store size and sign.
REQ-011 ex_rd  in  5  destination register.
REQ-012 ex_src_to_reg  in  2  writeback source select.
REQ-013 ex_reg_wr  in  1  instruction writes rd.
REQ-014 ex_mem_rd / ex_mem_wr  in  1 each  load / store.
REQ-015 dmem_req, dmem_we  out  1 each  data-memory request, write strobe.
REQ-016 dmem_addr  out  XLEN  word-aligned address; dmem_wdata  out  XLEN; dmem_be  out  4.
REQ-017 dmem_rvalid  in  1  access complete (read data valid or write ack); dmem_rdata  in  XLEN.
REQ-018 mem_wb_rd  out  5; mem_wb_data  out  XLEN; reg_mem_wb_wr  out  1  register-file writeback and bypass source.

Function
REQ-019 ex_ready SHALL equal (state == IDLE); an instruction is accepted on a rising edge with ex_valid && ex_ready.
REQ-020 FSM states: IDLE, MEM_WAIT; accepted load/store -> MEM_WAIT; MEM_WAIT -> IDLE on the edge where dmem_rvalid is 1; otherwise hold.
REQ-021 In MEM_WAIT, dmem_req SHALL be 1 with dmem_addr/we/wdata/be held stable from registered values until dmem_rvalid; dmem_req is 0 in IDLE.
REQ-022 Non-memory instruction: writeback outputs valid on the cycle after acceptance (latency 1).
REQ-023 Load: writeback outputs valid on the cycle after the dmem_rvalid cycle; store: no writeback.
REQ-024 reg_mem_wb_wr SHALL pulse exactly one cycle per retired instruction with ex_reg_wr = 1 and rd != 0; rd = 0 never asserts it.
REQ-025 Writeback mux: 00 ALU result, 01 aligned load data, 10 PC + 4 (mod 2^32), 11 immediate.
REQ-026 Load extract by funct3 and addr[1:0]: 000 LB sign-extend, 001 LH sign-extend (lane addr[1]), 010 LW, 100 LBU, 101 LHU zero-extend; other encodings behave as LW.
REQ-027 Store: SB be = 0001 << addr[1:0], byte replicated x4; SH be = 0011 << {addr[1],0}, half replicated x2; SW be = 1111.
REQ-028 dmem_rvalid in IDLE SHALL be ignored; ex_valid in MEM_WAIT is not accepted and upstream holds.

Reset
REQ-029 Reset SHALL force IDLE, dmem_req/dmem_we/reg_mem_wb_wr = 0, all data/address/rd outputs = 0, ex_ready = 1.
REQ-030 Reset in MEM_WAIT SHALL abandon the access; no writeback for it, and a later dmem_rvalid is ignored.

Configuration
REQ-031 Macro MISALIGN_TRAP_EN: when defined, adds output misalign (1 bit, reset 0); a misaligned LH/LHU/SH (addr[0]) or LW/SW (addr[1:0] != 0) is not issued, misalign pulses 1 cycle after acceptance, no writeback, FSM stays IDLE.
REQ-032 Without MISALIGN_TRAP_EN: port absent; offending low address bits are ignored (access aligned down).

Structure
REQ-033 Shared package rv32i_pkg SHALL hold funct3 load/store encodings, src_to_reg encodings and the FSM state type.
REQ-034 One sub-module, load_store_align: combinational byte-enable, store replication and load extract/extend.

Verification
REQ-035 ALU op rd=5, result 0x1234, src 00 -> next cycle rd=5, data 0x00001234, wr pulse 1 cycle.
REQ-036 LB addr 0x103, rdata 0x80FFFFFF, rvalid after 3 wait cycles -> req held 3+ cycles, be 1000, data 0xFFFFFF80.
REQ-037 SH addr 0x102, rs2 0xABCD -> be 1100, wdata 0xABCDABCD, no writeback, ex_ready low until rvalid.
REQ-038 JAL rd=1, PC 0xFFFFFFFC, src 10 -> data 0x00000000; any op with rd=0 -> wr stays 0.
REQ-039 Reset asserted in MEM_WAIT then rvalid -> req 0, no wr pulse, ex_ready 1.
REQ-040 MISALIGN_TRAP_EN defined, LW addr 0x102 -> no req, misalign 1 cycle, no wr.
